// File: rtl/multi_enabler.sv
// Multi-lane registered enabler: each lane opens after SETTLE consecutive
// enable-high samples, output goes through a DEPTH-stage register pipeline.
module multi_enabler #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 1,
    parameter int SETTLE   = 1,
    parameter int HOLD     = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*WIDTH-1:0]    in,
    input  logic [CHANNELS-1:0]          enable,
    output logic [CHANNELS*WIDTH-1:0]    out,
    output logic [CHANNELS-1:0]          active
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam int SW = CW + 1;
    localparam logic [CW-1:0] CMAX    = CW'(SETTLE);
    localparam logic [SW-1:0] SETTLEW = SW'(SETTLE);

    logic [CW-1:0]               cnt  [CHANNELS];
    logic [CHANNELS-1:0]         pass;
    logic [CHANNELS*WIDTH-1:0]   data [DEPTH];
    logic [CHANNELS-1:0]         act  [DEPTH];

    // cnt >= SETTLE-1 written as cnt+1 >= SETTLE so SETTLE=1 is not a constant compare
    always_comb begin
        pass = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            pass[c] = enable[c] && (({1'b0, cnt[c]} + 1'b1) >= SETTLEW);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                cnt[c] <= '0;
            end
            for (int unsigned s = 0; s < DEPTH; s++) begin
                data[s] <= '0;
                act[s]  <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (!enable[c]) begin
                    cnt[c] <= '0;
                end else if (cnt[c] != CMAX) begin
                    cnt[c] <= cnt[c] + 1'b1;
                end
                if (pass[c]) begin
                    data[0][c*WIDTH +: WIDTH] <= in[c*WIDTH +: WIDTH];
                end else if (HOLD == 0) begin
                    data[0][c*WIDTH +: WIDTH] <= '0;
                end
            end
            act[0] <= pass;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                data[s] <= data[s-1];
                act[s]  <= act[s-1];
            end
        end
    end

    assign out    = data[DEPTH-1];
    assign active = act[DEPTH-1];
endmodule

// File: tb/tb_multi_enabler.sv
// Self-checking bench: HOLD=0 and HOLD=1 instances share stimulus and are
// compared against a run-length / delay-queue reference model.
module tb_multi_enabler;
    localparam int W = 8;
    localparam int C = 4;
    localparam int D = 2;
    localparam int S = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [C*W-1:0]   in;
    logic [C-1:0]     enable;
    logic [C*W-1:0]   out0, out1;
    logic [C-1:0]     act0, act1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [C-1:0]   a;
        logic [C*W-1:0] d0;
        logic [C*W-1:0] d1;
    } slot_t;

    slot_t          pipe[$];
    int             run  [C];
    logic [W-1:0]   last [C];

    multi_enabler #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .SETTLE(S), .HOLD(0)) dut0 (
        .clk(clk), .reset(reset), .in(in), .enable(enable), .out(out0), .active(act0));
    multi_enabler #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .SETTLE(S), .HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .in(in), .enable(enable), .out(out1), .active(act1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        slot_t z;
        z.a = '0; z.d0 = '0; z.d1 = '0;
        for (int c = 0; c < C; c++) begin
            run[c]  = 0;
            last[c] = '0;
        end
        pipe.delete();
        for (int i = 0; i < D; i++) pipe.push_back(z);
    endtask

    // One clock: drive inputs, update the model at the edge, compare both DUTs.
    task automatic step(input logic rst, input logic [C-1:0] en, input logic [C*W-1:0] din);
        slot_t s;
        reset  = rst;
        enable = en;
        in     = din;
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            s.a = '0; s.d0 = '0; s.d1 = '0;
            for (int c = 0; c < C; c++) begin
                run[c] = en[c] ? run[c] + 1 : 0;
                if (run[c] >= S) begin
                    s.a[c]         = 1'b1;
                    s.d0[c*W +: W] = din[c*W +: W];
                    s.d1[c*W +: W] = din[c*W +: W];
                    last[c]        = din[c*W +: W];
                end else begin
                    s.d1[c*W +: W] = last[c];
                end
            end
            pipe.push_back(s);
            void'(pipe.pop_front());
        end
        #1;
        check("model_out_h0",    64'(out0), 64'(pipe[0].d0));
        check("model_active_h0", 64'(act0), 64'(pipe[0].a));
        check("model_out_h1",    64'(out1), 64'(pipe[0].d1));
        check("model_active_h1", 64'(act1), 64'(pipe[0].a));
    endtask

    initial begin
        logic [C*W-1:0] r;
        logic [C-1:0]   e;
        model_clear();
        reset = 1'b0; enable = '0; in = '0;

        // Reset with enable asserted
        step(1'b0, 4'hF, 32'hABABABAB);
        step(1'b0, 4'hF, 32'hABABABAB);
        check("reset_out",    64'(out1), 64'h0);
        check("reset_active", 64'(act0), 64'h0);

        // Settle and latency on lane 0: edges 0..2 closed, open after edge 3
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'b0001, 32'h000000AB);
            check("settle_closed", 64'(act0[0]), 64'h0);
        end
        step(1'b1, 4'b0001, 32'h000000AB);
        check("open_active", 64'(act0[0]), 64'h1);
        check("open_out",    64'(out0[7:0]), 64'hAB);

        // Disable while input changes
        step(1'b1, 4'b0000, 32'h000000CD);
        check("close_lag_active", 64'(act0[0]), 64'h1);
        step(1'b1, 4'b0000, 32'h000000CD);
        check("close_h0_out",    64'(out0[7:0]), 64'h00);
        check("close_h1_out",    64'(out1[7:0]), 64'hAB);
        check("close_h1_active", 64'(act1[0]), 64'h0);

        // Glitch: 2 high, 1 low, then full re-settle needed
        step(1'b1, 4'b0001, 32'h000000CD);
        step(1'b1, 4'b0001, 32'h000000CD);
        step(1'b1, 4'b0000, 32'h000000CD);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'b0001, 32'h000000CD);
            check("glitch_closed", 64'(act0[0]), 64'h0);
        end
        step(1'b1, 4'b0001, 32'h000000CD);
        check("glitch_reopen", 64'(act0[0]), 64'h1);
        step(1'b1, 4'b0001, 32'h000000EF);
        check("track_lag", 64'(out0[7:0]), 64'hCD);
        step(1'b1, 4'b0001, 32'h000000EF);
        check("track_new", 64'(out0[7:0]), 64'hEF);

        // Independent lanes
        step(1'b1, 4'b0000, 32'h44332211);
        step(1'b1, 4'b0000, 32'h44332211);
        for (int k = 0; k < 4; k++) step(1'b1, 4'b0101, 32'h44332211);
        check("lanes_out",    64'(out0), 64'h00330011);
        check("lanes_active", 64'(act0), 64'h5);

        // Mid-operation reset loses held values; reopen takes 4 edges
        step(1'b0, 4'b0101, 32'h44332211);
        check("midrst_out_h1",    64'(out1), 64'h0);
        check("midrst_active_h1", 64'(act1), 64'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'b0101, 32'h44332211);
            check("midrst_closed", 64'(act1), 64'h0);
        end
        step(1'b1, 4'b0101, 32'h44332211);
        check("midrst_reopen",     64'(act1), 64'h5);
        check("midrst_reopen_out", 64'(out1), 64'h00330011);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            r = $urandom();
            for (int c = 0; c < C; c++) e[c] = ($urandom_range(0, 4) != 0);
            step(($urandom_range(0, 60) != 0), e, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
